// File: rtl/xchg_reg_file.sv
// -----------------------------------------------------------------------------
// xchg_reg_file
// Register file with one external write port, one combinational read port and
// a small command engine that performs atomic SWAP / COPY / CLEAR operations
// between two entries.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset (clears FSM, engine and storage)
//   we         - external write enable (only honoured while the engine is idle)
//   address_w  - external write address
//   data_w     - external write data
//   address_r  - read address
//   data_r     - combinational read data, mem[address_r]
//   cmd_valid  - command request
//   cmd_op     - 00 SWAP A<->B, 01 COPY A->B, 10 CLEAR B<=0, 11 reserved
//   address_A  - operand A, sampled on accept
//   address_B  - operand B, sampled on accept
//   cmd_ready  - engine can accept a command this cycle
//   busy       - command in progress
//   done       - registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module xchg_reg_file #(
  parameter int ADDR_width = 7,
  parameter int DATA_width = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_width-1:0] address_w,
  input  logic [DATA_width-1:0] data_w,
  input  logic [ADDR_width-1:0] address_r,
  output logic [DATA_width-1:0] data_r,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_width-1:0] address_A,
  input  logic [ADDR_width-1:0] address_B,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_width;

  localparam logic [1:0] OP_SWAP  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR1  = 2'd1,
    S_WR2  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [DATA_width-1:0] r_mem [DEPTH];
  logic [ADDR_width-1:0] r_addr_a;
  logic [ADDR_width-1:0] r_addr_b;
  logic [1:0]            r_op;
  logic [DATA_width-1:0] r_tmp;
  logic                  r_done;

  logic                  w_cmd_ready;
  logic                  w_busy;
  logic                  w_accept;

  // Reserved opcode is never accepted, but cmd_ready itself is unaffected.
  assign w_accept = cmd_valid & w_cmd_ready & (cmd_op != OP_RSVD);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Only SWAP needs the extra A-write cycle.
          w_next_state = (cmd_op == OP_SWAP) ? S_WR1 : S_WR2;
        end
      end
      S_WR1:   w_next_state = S_WR2;
      S_WR2:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cmd_ready = 1'b0;
    w_busy      = 1'b0;
    if (r_state == S_IDLE) begin
      // An external write in the same idle cycle takes priority over a command.
      w_cmd_ready = ~we;
    end else begin
      w_busy = 1'b1;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign busy      = w_busy;
  assign done      = r_done;

  // ---------------------------------------------------------------------------
  // Command latches and temporary holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_op     <= '0;
      r_tmp    <= '0;
    end else if (w_accept) begin
      r_addr_a <= address_A;
      r_addr_b <= address_B;
      r_op     <= cmd_op;
      r_tmp    <= (cmd_op == OP_CLEAR) ? '0 : r_mem[address_A];
    end
  end

  // done is registered: it goes high in the cycle after the final B write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_WR2);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: external write while idle, A-write in WR1, B-write in WR2
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (we) begin
            r_mem[address_w] <= data_w;
          end
        end
        S_WR1: begin
          if (r_op == OP_SWAP) begin
            r_mem[r_addr_a] <= r_mem[r_addr_b];
          end
        end
        S_WR2: begin
          r_mem[r_addr_b] <= r_tmp;
        end
        default: ;
      endcase
    end
  end

  assign data_r = r_mem[address_r];

endmodule

// File: tb/tb_xchg_reg_file.sv
module tb_xchg_reg_file;

  logic       clk;
  logic       reset_n;
  logic       we;
  logic [6:0] address_w;
  logic [7:0] data_w;
  logic [6:0] address_r;
  logic [7:0] data_r;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [6:0] address_A;
  logic [6:0] address_B;
  logic       cmd_ready;
  logic       busy;
  logic       done;

  int total;
  int bad;

  // Behavioural reference: plain array of entry contents.
  logic [7:0] model [128];

  xchg_reg_file #(.ADDR_width(7), .DATA_width(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (we),
    .address_w (address_w),
    .data_w    (data_w),
    .address_r (address_r),
    .data_r    (data_r),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .address_A (address_A),
    .address_B (address_B),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
  endtask

  task automatic read_chk(input logic [6:0] addr, input logic [7:0] exp, input string nm);
    address_r = addr;
    #1;
    total++;
    if (data_r !== exp) begin
      bad++;
      $display("FAIL %s addr=%0d got=%h want=%h", nm, addr, data_r, exp);
    end
  endtask

  task automatic wr(input logic [6:0] addr, input logic [7:0] d);
    we = 1'b1; address_w = addr; data_w = d;
    tick();
    we = 1'b0;
    model[addr] = d;
  endtask

  // Issue one command from an idle (or done) cycle and follow it to completion.
  // Returns in the cycle where done is observed high.
  task automatic do_cmd(input logic [1:0] op, input logic [6:0] a, input logic [6:0] b, input string nm);
    int         exp_lat;
    int         lat;
    int         busy_n;
    logic [7:0] old_a;
    logic [7:0] old_b;
    exp_lat = (op == 2'b00) ? 3 : 2;
    old_a = model[a];
    old_b = model[b];
    cmd_op = op; address_A = a; address_B = b; cmd_valid = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready got=%b want=1", nm, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    // Operands may wander after accept; only the latched copies matter.
    address_A = 7'($urandom);
    address_B = 7'($urandom);
    lat = 0;
    busy_n = 0;
    for (int j = 1; j <= 8; j++) begin
      if (done === 1'b1) begin
        lat = j;
        break;
      end
      if (busy === 1'b1) busy_n++;
      if (op == 2'b00 && j == 2) read_chk(a, old_b, {nm, "_mid"});
      tick();
    end
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=%0d", nm, lat, exp_lat);
    end
    total++;
    if (busy_n != exp_lat - 1) begin
      bad++;
      $display("FAIL %s_busy_cycles got=%0d want=%0d", nm, busy_n, exp_lat - 1);
    end
    case (op)
      2'b00: begin model[a] = old_b; model[b] = old_a; end
      2'b01: model[b] = old_a;
      default: model[b] = 8'h00;
    endcase
  endtask

  task automatic test_reset();
    reset_n = 1'b0; we = 1'b0; cmd_valid = 1'b0;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b%b%b want=100", cmd_ready, busy, done);
    end
    we = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_we got=%b want=0", cmd_ready);
    end
    we = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    model_clear();
    for (int i = 0; i < 128; i++) read_chk(7'(i), 8'h00, "reset_mem");
    tick();
  endtask

  task automatic test_swap();
    wr(7'd3, 8'h5A);
    wr(7'd9, 8'hC3);
    do_cmd(2'b00, 7'd3, 7'd9, "swap");
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL swap_done_once got=%b want=0", done);
    end
    read_chk(7'd3, 8'hC3, "swap_a");
    read_chk(7'd9, 8'h5A, "swap_b");
    tick();
  endtask

  task automatic test_copy_clear();
    do_cmd(2'b01, 7'd3, 7'd20, "copy");
    tick();
    read_chk(7'd20, 8'hC3, "copy_b");
    read_chk(7'd3, 8'hC3, "copy_a");
    tick();
    do_cmd(2'b10, 7'd0, 7'd20, "clear");
    tick();
    read_chk(7'd20, 8'h00, "clear_b");
    tick();
  endtask

  task automatic test_we_busy();
    logic [7:0] old5;
    logic [7:0] m3;
    logic [7:0] m9;
    old5 = model[5]; m3 = model[3]; m9 = model[9];
    cmd_op = 2'b00; address_A = 7'd3; address_B = 7'd9; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    we = 1'b1; address_w = 7'd5; data_w = 8'hFF;
    tick();
    tick();
    we = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL webusy_done got=%b want=1", done);
    end
    model[3] = m9; model[9] = m3;
    read_chk(7'd5, old5, "webusy_ignored");
    read_chk(7'd3, model[3], "webusy_swap_a");
    tick();
    // Write and command together in idle: the write wins.
    we = 1'b1; address_w = 7'd5; data_w = 8'h77;
    cmd_valid = 1'b1; cmd_op = 2'b01; address_A = 7'd3; address_B = 7'd5;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL we_cmd_ready got=%b want=0", cmd_ready);
    end
    tick();
    we = 1'b0; cmd_valid = 1'b0;
    model[5] = 8'h77;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL we_cmd_busy got=%b want=0", busy);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL we_cmd_done got=%b want=0", done);
    end
    read_chk(7'd5, 8'h77, "we_cmd_write");
    tick();
  endtask

  task automatic test_reserved();
    cmd_valid = 1'b1; cmd_op = 2'b11; address_A = 7'd3; address_B = 7'd9;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL rsvd_ctrl cyc=%0d got=%b%b%b want=001", k, busy, done, cmd_ready);
      end
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_done got=%b want=0", done);
    end
    read_chk(7'd3, model[3], "rsvd_a");
    read_chk(7'd9, model[9], "rsvd_b");
    tick();
  endtask

  task automatic test_same_addr();
    wr(7'd7, 8'h11);
    do_cmd(2'b00, 7'd7, 7'd7, "swap_same");
    tick();
    read_chk(7'd7, 8'h11, "swap_same_val");
    tick();
    do_cmd(2'b10, 7'd7, 7'd7, "clear_same");
    tick();
    read_chk(7'd7, 8'h00, "clear_same_val");
    tick();
  endtask

  task automatic test_back_to_back();
    wr(7'd40, 8'hA1);
    wr(7'd41, 8'hB2);
    do_cmd(2'b00, 7'd40, 7'd41, "b2b_swap");
    do_cmd(2'b01, 7'd41, 7'd42, "b2b_copy");
    do_cmd(2'b00, 7'd42, 7'd40, "b2b_swap2");
    tick();
    read_chk(7'd40, model[40], "b2b_40");
    read_chk(7'd41, model[41], "b2b_41");
    read_chk(7'd42, model[42], "b2b_42");
    tick();
  endtask

  task automatic test_reset_mid();
    int dn;
    wr(7'd3, 8'h5A);
    wr(7'd9, 8'hC3);
    cmd_op = 2'b00; address_A = 7'd3; address_B = 7'd9; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ctrl got=%b%b want=00", busy, done);
    end
    model_clear();
    read_chk(7'd3, 8'h00, "midrst_a");
    read_chk(7'd9, 8'h00, "midrst_b");
    tick();
    reset_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    total++;
    if (dn != 0) begin
      bad++;
      $display("FAIL midrst_nodone got=%0d want=0", dn);
    end
    wr(7'd3, 8'h21);
    wr(7'd9, 8'h43);
    do_cmd(2'b00, 7'd3, 7'd9, "postrst_swap");
    tick();
    read_chk(7'd3, 8'h43, "postrst_a");
    read_chk(7'd9, 8'h21, "postrst_b");
    tick();
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic [6:0] b;
    logic [1:0] op;
    for (int n = 0; n < 60; n++) begin
      a = 7'($urandom_range(0, 15));
      b = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        wr(a, 8'($urandom));
      end else begin
        op = 2'($urandom_range(0, 2));
        do_cmd(op, a, b, "rand_cmd");
        read_chk(a, model[a], "rand_a");
        read_chk(b, model[b], "rand_b");
        tick();
      end
    end
    for (int i = 0; i < 16; i++) read_chk(7'(i), model[i], "rand_final");
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; we = 1'b0; address_w = '0; data_w = '0; address_r = '0;
    cmd_valid = 1'b0; cmd_op = '0; address_A = '0; address_B = '0;
    model_clear();
    test_reset();
    test_swap();
    test_copy_clear();
    test_we_busy();
    test_reserved();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
